ili9488_init_seq: RTL and testbench
===================================

ILI9488_INIT_SEQ -- requirements
Module: ili9488_init_seq

Interface
REQ-001 Parameter TICKS_PER_MS, default 50000, clock cycles per millisecond of delay.
REQ-002 Parameter RST_LOW_MS, default 10, duration of lcd_rst_n low pulse in ms.
REQ-003 Parameter RST_WAIT_MS, default 120, wait after lcd_rst_n release in ms.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ready  input  1  downstream byte transmitter can accept a byte this cycle.
REQ-007 data_out  output  8  byte to transmit (command opcode or parameter).
REQ-008 cs  output  1  panel chip select, active low.
REQ-009 dc  output  1  0 = command byte, 1 = parameter byte.
REQ-010 sd  output  1  send request; byte accepted on a cycle with sd=1 and ready=1.
REQ-011 lcd_rst_n  output  1  panel hardware reset, active low.
REQ-012 init_done  output  1  high once sequence complete; selects drawing path at bus mux.

Function
REQ-013 Block SHALL contain a 64-entry x 10-bit internal ROM; entry[9:8] type: 00 CMD, 01 DATA, 10 DELAY (entry[7:0] = ms, 0 = no wait), 11 END; entry[7:0] value.
REQ-014 ROM contents SHALL be: CMD 01, DELAY 120, CMD 11, DELAY 120, CMD 3A, DATA 55, CMD 36, DATA 48, CMD 29, DELAY 20, END; unused entries END.
REQ-015 States SHALL be RST_LOW, RST_WAIT, FETCH, SEND, DELAY, DONE.
REQ-016 RST_LOW: lcd_rst_n=0 for RST_LOW_MS*TICKS_PER_MS cycles, then -> RST_WAIT.
REQ-017 RST_WAIT: lcd_rst_n=1 for RST_WAIT_MS*TICKS_PER_MS cycles, then -> FETCH with pointer 0.
REQ-018 FETCH: one cycle, registers ROM entry at pointer; next state by type: CMD/DATA -> SEND, DELAY -> DELAY, END -> DONE.
REQ-019 SEND: sd=1, cs=0, dc=type[0], data_out=entry value, all held stable until cycle with ready=1.
REQ-020 On sd&ready, pointer SHALL increment and state -> FETCH next cycle; sd SHALL be 0 in that FETCH cycle.
REQ-021 DELAY: sd=0, cs=1, wait value*TICKS_PER_MS cycles (0 -> exactly one cycle), pointer increments, -> FETCH.
REQ-022 Millisecond counter SHALL be 32 bits wide; ms counter 8 bits; no overflow for parameter range TICKS_PER_MS <= 2^24.
REQ-023 cs SHALL be 0 only in SEND; 1 in all other states, so each command group is framed between delays.
REQ-024 Pointer at 63 reaching end without END entry SHALL force DONE (no wrap-around).
REQ-025 DONE: init_done=1, sd=0, cs=1, lcd_rst_n=1, state held until reset.
REQ-026 ready SHALL be ignored in all states except SEND; ready high during FETCH/DELAY SHALL cause no transfer.
REQ-027 Outputs SHALL be registered; init_done SHALL rise one cycle after END entry is fetched.

Reset
REQ-028 rst_n low SHALL immediately force: state RST_LOW, pointer 0, counters 0, data_out=00, cs=1, dc=0, sd=0, lcd_rst_n=0, init_done=0.
REQ-029 Reset asserted mid-SEND or mid-DELAY SHALL abort the transfer; sequence restarts from RST_LOW after release.
REQ-030 init_done SHALL fall asynchronously on rst_n low, returning bus control to the init path.

Verification
REQ-031 TICKS_PER_MS=4, RST_LOW_MS=2, RST_WAIT_MS=3, ready=1 constant -> lcd_rst_n low 8 cycles, high; first sd with data_out=01 dc=0 after 12 further cycles + 1 FETCH.
REQ-032 Full run, ready=1 -> accepted bytes in order 01,11,3A,55,36,48,29 with dc 0,0,0,1,0,1,0; gaps of 480 cycles after 01 and 11; init_done=1 after 80-cycle delay following 29.
REQ-033 ready held 0 for 5 cycles during CMD 3A -> sd, data_out=3A, dc=0, cs=0 stable all 5 cycles; single transfer when ready rises.
REQ-034 ready toggled high during DELAY states -> no sd pulse, byte count unchanged.
REQ-035 rst_n pulsed low during DATA 55 SEND -> outputs at reset values same cycle; after release sequence replays from lcd_rst_n low, 01 first.
REQ-036 After init_done=1, ready toggling for 100 cycles -> sd stays 0, init_done stays 1.

Source files
------------

// File: rtl/ili9488_init_seq.sv
// ILI9488 panel power-up sequencer.
// Pulses the panel hardware reset, waits for the controller to come up, then
// walks a small command ROM and hands bytes to a downstream transmitter
// through an sd/ready handshake. Inline millisecond delays in the ROM are
// honoured with cs released, so each command group is framed. When the END
// entry is reached, init_done rises and the bus mux hands the panel to the
// drawing path.
module ili9488_init_seq #(
  parameter int TICKS_PER_MS = 50000,
  parameter int RST_LOW_MS   = 10,
  parameter int RST_WAIT_MS  = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  output logic [7:0] data_out,
  output logic       cs,
  output logic       dc,
  output logic       sd,
  output logic       lcd_rst_n,
  output logic       init_done
);

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    FETCH,
    SEND,
    DELAY,
    DONE
  } state_t;

  localparam logic [31:0] TICK_LAST    = 32'(TICKS_PER_MS - 1);
  localparam logic [7:0]  RST_LOW_MS8  = 8'(RST_LOW_MS);
  localparam logic [7:0]  RST_WAIT_MS8 = 8'(RST_WAIT_MS);
  localparam logic [5:0]  PTR_LAST     = 6'd63;

  // Entry layout: [9:8] type (00 CMD, 01 DATA, 10 DELAY ms, 11 END), [7:0] value.
  function automatic logic [9:0] rom_entry(input logic [5:0] addr);
    logic [9:0] e;
    case (addr)
      6'd0:    e = 10'h001;  // CMD  01 software reset
      6'd1:    e = 10'h278;  // DELAY 120 ms
      6'd2:    e = 10'h011;  // CMD  11 sleep out
      6'd3:    e = 10'h278;  // DELAY 120 ms
      6'd4:    e = 10'h03A;  // CMD  3A pixel format
      6'd5:    e = 10'h155;  // DATA 55 16 bpp
      6'd6:    e = 10'h036;  // CMD  36 memory access control
      6'd7:    e = 10'h148;  // DATA 48
      6'd8:    e = 10'h029;  // CMD  29 display on
      6'd9:    e = 10'h214;  // DELAY 20 ms
      default: e = 10'h300;  // END
    endcase
    return e;
  endfunction

  // A wait of zero milliseconds still occupies exactly one cycle.
  function automatic logic ms_expired(input logic [7:0] target,
                                      input logic [7:0] ms,
                                      input logic       tick_wrap);
    return (target == 8'd0) || (tick_wrap && (ms == target - 8'd1));
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [31:0] tick_q, tick_d;
  logic [7:0]  ms_q, ms_d;
  logic [7:0]  val_q, val_d;
  logic [7:0]  data_q, data_d;
  logic        dc_q, dc_d;
  logic        sd_q, sd_d;
  logic        cs_q, cs_d;
  logic        lrst_q, lrst_d;
  logic        done_q, done_d;

  logic [9:0]  rom_w;
  logic        tick_wrap;
  logic [31:0] tick_adv;
  logic [7:0]  ms_adv;

  assign rom_w     = rom_entry(ptr_q);
  assign tick_wrap = (tick_q == TICK_LAST);
  assign tick_adv  = tick_wrap ? 32'd0 : tick_q + 32'd1;
  assign ms_adv    = tick_wrap ? ms_q + 8'd1 : ms_q;

  // Next-state logic; output values are computed for the state being entered
  // so that the registered outputs line up with that state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    val_d   = val_q;
    data_d  = data_q;
    dc_d    = dc_q;
    sd_d    = 1'b0;
    cs_d    = 1'b1;
    lrst_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      RST_LOW: begin
        lrst_d = 1'b0;
        if (ms_expired(RST_LOW_MS8, ms_q, tick_wrap)) begin
          state_d = RST_WAIT;
          tick_d  = 32'd0;
          ms_d    = 8'd0;
          lrst_d  = 1'b1;
        end else begin
          tick_d = tick_adv;
          ms_d   = ms_adv;
        end
      end
      RST_WAIT: begin
        if (ms_expired(RST_WAIT_MS8, ms_q, tick_wrap)) begin
          state_d = FETCH;
          ptr_d   = 6'd0;
          tick_d  = 32'd0;
          ms_d    = 8'd0;
        end else begin
          tick_d = tick_adv;
          ms_d   = ms_adv;
        end
      end
      FETCH: begin
        val_d = rom_w[7:0];
        unique case (rom_w[9:8])
          2'b00, 2'b01: begin
            state_d = SEND;
            sd_d    = 1'b1;
            cs_d    = 1'b0;
            dc_d    = rom_w[8];
            data_d  = rom_w[7:0];
          end
          2'b10: begin
            state_d = DELAY;
            tick_d  = 32'd0;
            ms_d    = 8'd0;
          end
          default: begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        endcase
      end
      SEND: begin
        if (ready) begin
          if (ptr_q == PTR_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            ptr_d   = ptr_q + 6'd1;
          end
        end else begin
          sd_d = 1'b1;
          cs_d = 1'b0;
        end
      end
      DELAY: begin
        if (ms_expired(val_q, ms_q, tick_wrap)) begin
          tick_d = 32'd0;
          ms_d   = 8'd0;
          if (ptr_q == PTR_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            ptr_d   = ptr_q + 6'd1;
          end
        end else begin
          tick_d = tick_adv;
          ms_d   = ms_adv;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = RST_LOW;
        lrst_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state, ROM pointer and delay counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_LOW;
      ptr_q   <= 6'd0;
      tick_q  <= 32'd0;
      ms_q    <= 8'd0;
      val_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      val_q   <= val_d;
    end
  end

  // Registered panel-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      dc_q   <= 1'b0;
      sd_q   <= 1'b0;
      cs_q   <= 1'b1;
      lrst_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      dc_q   <= dc_d;
      sd_q   <= sd_d;
      cs_q   <= cs_d;
      lrst_q <= lrst_d;
      done_q <= done_d;
    end
  end

  assign data_out  = data_q;
  assign dc        = dc_q;
  assign sd        = sd_q;
  assign cs        = cs_q;
  assign lcd_rst_n = lrst_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_ili9488_init_seq.sv
// Bench for ili9488_init_seq with a short millisecond (4 cycles) so full
// sequences complete quickly. Accepted bytes are checked against a queue of
// expected bytes by an independent monitor.
module tb_ili9488_init_seq;

  localparam int M_CONST  = 0;
  localparam int M_STALL  = 1;
  localparam int M_ABORT  = 2;
  localparam int M_TOGGLE = 3;

  logic       clk;
  logic       rst_n;
  logic       ready;
  logic [7:0] data_out;
  logic       cs;
  logic       dc;
  logic       sd;
  logic       lcd_rst_n;
  logic       init_done;

  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   ncyc = 0;
  int   last_acc = 0;
  int   done_cyc = 0;
  bit   done_seen = 0;
  int   nbytes = 0;
  int   mode = M_CONST;
  int   stall_n = 0;
  int   stall_total = 0;
  bit   abort_req = 0;
  bit   tog = 0;

  ili9488_init_seq #(
    .TICKS_PER_MS(4),
    .RST_LOW_MS  (2),
    .RST_WAIT_MS (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .data_out (data_out),
    .cs       (cs),
    .dc       (dc),
    .sd       (sd),
    .lcd_rst_n(lcd_rst_n),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    check(nm, {19'd0, data_out, cs, dc, sd, lcd_rst_n, init_done},
          {19'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic push(input logic [7:0] b, input logic d, input int gap);
    exp_t e;
    e.b = b;
    e.dc = d;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Hand-computed accept-to-accept spacing with ready high:
  // after a 120 ms delay: FETCH + 480 DELAY + FETCH + SEND = 483 cycles;
  // back-to-back bytes: FETCH + SEND = 2 cycles.
  task automatic push_full(input bit gaps);
    push(8'h01, 1'b0, 0);
    push(8'h11, 1'b0, gaps ? 483 : 0);
    push(8'h3A, 1'b0, gaps ? 483 : 0);
    push(8'h55, 1'b1, 2);
    push(8'h36, 1'b0, gaps ? 2 : 0);
    push(8'h48, 1'b1, gaps ? 2 : 0);
    push(8'h29, 1'b0, gaps ? 2 : 0);
  endtask

  // Release reset, then measure the panel reset pulse (8 cycles) and the
  // cycles from its release to the first sd (12 wait + 1 FETCH).
  task automatic release_seq(input string nm);
    int lo;
    int hi;
    lo = 0;
    hi = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!lcd_rst_n) lo++;
      else break;
    end
    check({nm, "_lcd_rst_low_cycles"}, lo, 8);
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sd) break;
      hi++;
    end
    check({nm, "_cycles_to_first_sd"}, hi, 13);
  endtask

  task automatic wait_done(input int lim, input string nm);
    for (int i = 0; i < lim && !done_seen; i++) @(posedge clk);
    check(nm, {31'd0, done_seen}, 32'd1);
  endtask

  // Ready driver: reacts to the registered outputs just after each edge.
  always begin
    @(posedge clk);
    #1;
    tog = ~tog;
    if (mode == M_TOGGLE) begin
      ready = tog;
    end else if (!sd) begin
      stall_n = 0;
      ready = (mode == M_CONST) ? 1'b1 : tog;
    end else if (mode == M_STALL && data_out == 8'h3A && stall_n < 5) begin
      ready = 1'b0;
      check("stall_hold_3A", {20'd0, sd, cs, dc, 1'b0, data_out},
            {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3A});
      stall_n++;
      stall_total++;
    end else if (mode == M_ABORT && dc && data_out == 8'h55) begin
      ready = 1'b0;
      abort_req = 1'b1;
    end else begin
      ready = 1'b1;
    end
  end

  // Monitor: every accepted byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst_n) begin
      done_seen = 1'b0;
    end else begin
      if (init_done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc = ncyc;
      end
      if (sd && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("byte_dc_cs", {22'd0, data_out, dc, cs}, {22'd0, e.b, e.dc, 1'b0});
          if (e.gap != 0) check("byte_spacing", ncyc - last_acc, e.gap);
        end
        last_acc = ncyc;
        nbytes++;
      end
    end
  end

  initial begin
    int bad;
    clk = 1'b0;
    rst_n = 1'b0;
    ready = 1'b0;

    repeat (3) @(posedge clk);
    #2 check_reset("reset_initial");

    // Full run, ready constantly high.
    mode = M_CONST;
    push_full(1'b1);
    release_seq("runA");
    wait_done(2000, "runA_done");
    // 29 accepted -> FETCH -> 80 DELAY -> FETCH(END) -> init_done = 83 cycles.
    check("runA_done_after_29", done_cyc - last_acc, 83);
    check("runA_queue_empty", exp_q.size(), 0);
    check("runA_byte_count", nbytes, 7);

    mode = M_TOGGLE;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sd || !init_done) bad++;
    end
    check("post_done_idle", bad, 0);
    check("post_done_byte_count", nbytes, 7);

    // Asynchronous reset from DONE; outputs drop before any clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("async_reset_from_done");

    // Ready toggling during delays, 5-cycle stall on CMD 3A.
    nbytes = 0;
    stall_total = 0;
    mode = M_STALL;
    push_full(1'b0);
    repeat (2) @(posedge clk);
    release_seq("runB");
    wait_done(3000, "runB_done");
    check("runB_queue_empty", exp_q.size(), 0);
    check("runB_byte_count", nbytes, 7);
    check("runB_stall_cycles", stall_total, 5);

    // Reset during DATA 55 SEND, then replay from the top.
    @(posedge clk);
    #3 rst_n = 1'b0;
    nbytes = 0;
    abort_req = 1'b0;
    mode = M_ABORT;
    push(8'h01, 1'b0, 0);
    push(8'h11, 1'b0, 0);
    push(8'h3A, 1'b0, 0);
    repeat (2) @(posedge clk);
    release_seq("runC");
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (abort_req) break;
    end
    check("runC_reached_55", {31'd0, abort_req}, 32'd1);
    rst_n = 1'b0;
    #1 check_reset("reset_mid_send");
    check("runC_bytes_before_abort", nbytes, 3);
    mode = M_CONST;
    abort_req = 1'b0;
    push_full(1'b1);
    repeat (2) @(posedge clk);
    release_seq("runC_replay");
    wait_done(2000, "runC_done");
    check("runC_queue_empty", exp_q.size(), 0);
    check("runC_byte_count", nbytes, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
